// File: rtl/seg7_scan_pkg.sv
// Shared constants and helpers for the 7-segment display blocks.
// Segment patterns are "lit" patterns in {g,f,e,d,c,b,a} order; pins are active-low.
package seg7_scan_pkg;

  localparam int         DIGITS    = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [6:0] HEX_0 = 7'h3F;
  localparam logic [6:0] HEX_1 = 7'h06;
  localparam logic [6:0] HEX_2 = 7'h5B;
  localparam logic [6:0] HEX_3 = 7'h4F;
  localparam logic [6:0] HEX_4 = 7'h66;
  localparam logic [6:0] HEX_5 = 7'h6D;
  localparam logic [6:0] HEX_6 = 7'h7D;
  localparam logic [6:0] HEX_7 = 7'h07;
  localparam logic [6:0] HEX_8 = 7'h7F;
  localparam logic [6:0] HEX_9 = 7'h6F;
  localparam logic [6:0] HEX_A = 7'h77;
  localparam logic [6:0] HEX_B = 7'h7C;
  localparam logic [6:0] HEX_C = 7'h39;
  localparam logic [6:0] HEX_D = 7'h5E;
  localparam logic [6:0] HEX_E = 7'h79;
  localparam logic [6:0] HEX_F = 7'h71;

  // Hex nibble to lit-segment pattern.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] lit;
    case (nib)
      4'h0:    lit = HEX_0;
      4'h1:    lit = HEX_1;
      4'h2:    lit = HEX_2;
      4'h3:    lit = HEX_3;
      4'h4:    lit = HEX_4;
      4'h5:    lit = HEX_5;
      4'h6:    lit = HEX_6;
      4'h7:    lit = HEX_7;
      4'h8:    lit = HEX_8;
      4'h9:    lit = HEX_9;
      4'hA:    lit = HEX_A;
      4'hB:    lit = HEX_B;
      4'hC:    lit = HEX_C;
      4'hD:    lit = HEX_D;
      4'hE:    lit = HEX_E;
      4'hF:    lit = HEX_F;
      default: lit = 7'h00;
    endcase
    return lit;
  endfunction

endpackage

// File: rtl/seg7_scan_edge_sync.sv
// edge_sync: SYNC-deep synchronizer followed by a registered rising-edge pulse.
// The pulse appears SYNC+1 clock edges after din rises; falling edges are ignored.
module edge_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC-1:0] sync_q, sync_d;
  logic            prev_q, prev_d;
  logic            rise_q, rise_d;

  // Shift the async input through the synchronizer and detect a 0->1 step.
  always_comb begin
    sync_d = {sync_q[SYNC-2:0], din};
    prev_d = sync_q[SYNC-1];
    rise_d = sync_q[SYNC-1] & ~prev_q;
  end

  // Synchronizer, history and pulse flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 8-digit multiplexed common-anode 7-segment driver.
// A rising edge of scan_clk advances to the next digit; the shadow word is
// captured only when the scan wraps to digit 0, so a frame never tears.
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int SYNC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_clk,
  input  logic [31:0]       data,
  input  logic [DIGITS-1:0] dp_in,
  input  logic [DIGITS-1:0] digit_en,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame
);

  localparam logic [2:0] IDX_LAST = 3'd7;

`ifdef SEG7_LZB_EN
  // Digit k (k>=1) is blanked when it and every nibble above it are zero.
  function automatic logic [DIGITS-1:0] lzb_mask(input logic [31:0] word);
    logic [DIGITS-1:0] mask;
    logic              zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (word[4*k +: 4] == 4'h0);
      mask[k]    = zero_above;
    end
    return mask;
  endfunction
`endif

  logic              tick_s;
  logic [2:0]        idx_q, idx_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0] shadow_en_q, shadow_en_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_q, frame_d;
  logic [3:0]        nib_s;
  logic [DIGITS-1:0] lzb_s;
  logic              vis_s;

  edge_sync #(.SYNC(SYNC)) u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (scan_clk),
    .rise (tick_s)
  );

  // Advance the digit on tick, reload the shadow on wrap, and form the next pin values
  // from the (possibly just-loaded) shadow so digit 0 of a new frame is never stale.
  always_comb begin
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    shadow_en_d = shadow_en_q;
    an_d        = an_q;
    seg_d       = seg_q;
    dp_d        = dp_q;
    frame_d     = 1'b0;
    nib_s       = 4'h0;
    lzb_s       = '0;
    vis_s       = 1'b0;
    if (tick_s) begin
      idx_d = idx_q + 3'd1;
      if (idx_q == IDX_LAST) begin
        shadow_d    = data;
        shadow_dp_d = dp_in;
        shadow_en_d = digit_en;
        frame_d     = 1'b1;
      end else begin
        frame_d = 1'b0;
      end
      nib_s = shadow_d[{idx_d, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
      lzb_s = lzb_mask(shadow_d);
`else
      lzb_s = '0;
`endif
      vis_s = shadow_en_d[idx_d] && !lzb_s[idx_d];
      if (vis_s) begin
        an_d  = ~(8'h01 << idx_d);
        seg_d = ~hex_decode(nib_s);
        dp_d  = ~shadow_dp_d[idx_d];
      end else begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end
    end else begin
      frame_d = 1'b0;
    end
  end

  // Scan state and registered pin drivers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q       <= IDX_LAST;
      shadow_q    <= 32'h0000_0000;
      shadow_dp_q <= '0;
      shadow_en_q <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      shadow_en_q <= shadow_en_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      frame_q     <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule
